// File: rtl/alu_iter_pkg.sv
// Shared op codes, FSM state encodings and op-class helpers for the
// iterative ALU.
package alu_iter_pkg;

   localparam int ALUOPS = 5;

   localparam logic [ALUOPS-1:0] ALU_ADD    = 5'd0;
   localparam logic [ALUOPS-1:0] ALU_SUB    = 5'd1;
   localparam logic [ALUOPS-1:0] ALU_SLL    = 5'd2;
   localparam logic [ALUOPS-1:0] ALU_SLT    = 5'd3;
   localparam logic [ALUOPS-1:0] ALU_SLTU   = 5'd4;
   localparam logic [ALUOPS-1:0] ALU_XOR    = 5'd5;
   localparam logic [ALUOPS-1:0] ALU_SRL    = 5'd6;
   localparam logic [ALUOPS-1:0] ALU_SRA    = 5'd7;
   localparam logic [ALUOPS-1:0] ALU_OR     = 5'd8;
   localparam logic [ALUOPS-1:0] ALU_AND    = 5'd9;
   localparam logic [ALUOPS-1:0] ALU_EQ     = 5'd10;
   localparam logic [ALUOPS-1:0] ALU_NEQ    = 5'd11;
   localparam logic [ALUOPS-1:0] ALU_GE     = 5'd12;
   localparam logic [ALUOPS-1:0] ALU_GEU    = 5'd13;
   localparam logic [ALUOPS-1:0] ALU_MUL    = 5'd14;
   localparam logic [ALUOPS-1:0] ALU_MULH   = 5'd15;
   localparam logic [ALUOPS-1:0] ALU_MULHSU = 5'd16;
   localparam logic [ALUOPS-1:0] ALU_MULHU  = 5'd17;
   localparam logic [ALUOPS-1:0] ALU_DIV    = 5'd18;
   localparam logic [ALUOPS-1:0] ALU_DIVU   = 5'd19;
   localparam logic [ALUOPS-1:0] ALU_REM    = 5'd20;
   localparam logic [ALUOPS-1:0] ALU_REMU   = 5'd21;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_DIV  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   function automatic logic is_mul_op(input logic [ALUOPS-1:0] op);
      return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
   endfunction

   function automatic logic is_div_op(input logic [ALUOPS-1:0] op);
      return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
   endfunction

endpackage

// File: rtl/alu_muldiv_core.sv
// Radix-2 shift-add multiplier and restoring divider on unsigned
// magnitudes, sharing one hi/lo register pair and iteration counter.
module alu_muldiv_core #(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_start,
   input  logic            i_flush,
   input  logic            i_div,
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   output logic            o_done,
   output logic [XLEN-1:0] o_hi,
   output logic [XLEN-1:0] o_lo
);

   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

   logic            active_q, active_d;
   logic            div_q, div_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] hi_q, hi_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic [XLEN-1:0] b_q, b_d;
   logic [XLEN-1:0] addend;
   logic [XLEN:0]   sum;
   logic [XLEN:0]   r_sh;
   logic [XLEN:0]   diff;

   always_comb begin
      addend   = lo_q[0] ? b_q : '0;
      sum      = {1'b0, hi_q} + {1'b0, addend};
      r_sh     = {hi_q, lo_q[XLEN-1]};
      diff     = r_sh - {1'b0, b_q};
      active_d = active_q;
      div_d    = div_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      b_d      = b_q;
      if (i_flush) begin
         active_d = 1'b0;
      end else if (i_start) begin
         active_d = 1'b1;
         div_d    = i_div;
         cnt_d    = '0;
         hi_d     = '0;
         lo_d     = i_a;
         b_d      = i_b;
      end else if (active_q) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == LAST)
            active_d = 1'b0;
         // lo holds the multiplier / dividend and shifts out as the
         // product low half / quotient shifts in.
         if (div_q) begin
            if (!diff[XLEN]) begin
               hi_d = diff[XLEN-1:0];
               lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
               hi_d = r_sh[XLEN-1:0];
               lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
         end else begin
            hi_d = sum[XLEN:1];
            lo_d = {sum[0], lo_q[XLEN-1:1]};
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         active_q <= 1'b0;
         div_q    <= 1'b0;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         b_q      <= '0;
      end else begin
         active_q <= active_d;
         div_q    <= div_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         b_q      <= b_d;
      end
   end

   assign o_done = active_q && (cnt_q == LAST);
   assign o_hi   = hi_d;
   assign o_lo   = lo_d;

endmodule

// File: rtl/alu_iter.sv
// Handshaked execute-stage ALU: single-cycle RV32I ops plus iterative
// M-extension multiply/divide.
module alu_iter
   import alu_iter_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int SHW  = $clog2(XLEN),
   parameter int OPW  = 5
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [OPW-1:0]  i_alu_op,
   input  logic [XLEN-1:0] i_data_1,
   input  logic [XLEN-1:0] i_data_2,
   input  logic            i_flush,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [XLEN-1:0] o_result,
   output logic            o_busy
);

   localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

   logic [1:0]      state_q, state_d;
   logic [OPW-1:0]  op_q, op_d;
   logic            sign_q, sign_d;
   logic [XLEN-1:0] result_q, result_d;

   logic [SHW-1:0]  shamt;
   logic [XLEN-1:0] base_res, spec_res, md_res;
   logic [XLEN-1:0] a_mag, b_mag;
   logic            a_sgn, b_sgn, sgn_in;
   logic            mul_op, div_op, div0, ovf, start;
   logic            core_done;
   logic [XLEN-1:0] core_hi, core_lo;
   logic [2*XLEN-1:0] prod, prod_n;
   logic [XLEN-1:0] quot_n, rem_n;

   assign shamt = i_data_2[SHW-1:0];

   always_comb begin
      base_res = i_data_1 + i_data_2;
      unique case (i_alu_op)
         ALU_SUB:  base_res = i_data_1 - i_data_2;
         ALU_SLL:  base_res = i_data_1 << shamt;
         ALU_SLT:  base_res = XLEN'($signed(i_data_1) < $signed(i_data_2));
         ALU_SLTU: base_res = XLEN'(i_data_1 < i_data_2);
         ALU_XOR:  base_res = i_data_1 ^ i_data_2;
         ALU_SRL:  base_res = i_data_1 >> shamt;
         ALU_SRA:  base_res = $signed(i_data_1) >>> shamt;
         ALU_OR:   base_res = i_data_1 | i_data_2;
         ALU_AND:  base_res = i_data_1 & i_data_2;
         ALU_EQ:   base_res = XLEN'(i_data_1 == i_data_2);
         ALU_NEQ:  base_res = XLEN'(i_data_1 != i_data_2);
         ALU_GE:   base_res = XLEN'($signed(i_data_1) >= $signed(i_data_2));
         ALU_GEU:  base_res = XLEN'(i_data_1 >= i_data_2);
         default:  base_res = i_data_1 + i_data_2;
      endcase
   end

   always_comb begin
      mul_op = is_mul_op(i_alu_op);
      div_op = is_div_op(i_alu_op);
      a_sgn  = i_data_1[XLEN-1] &&
               (i_alu_op inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM});
      b_sgn  = i_data_2[XLEN-1] &&
               (i_alu_op inside {ALU_MULH, ALU_DIV, ALU_REM});
      a_mag  = a_sgn ? -i_data_1 : i_data_1;
      b_mag  = b_sgn ? -i_data_2 : i_data_2;
      // Remainder follows the dividend; everything else follows a^b.
      sgn_in = (i_alu_op == ALU_REM) ? a_sgn : (a_sgn ^ b_sgn);
      div0   = (i_data_2 == '0);
      ovf    = (i_alu_op == ALU_DIV || i_alu_op == ALU_REM) &&
               (i_data_1 == XMIN) && (i_data_2 == '1);
      if (div0)
         spec_res = (i_alu_op == ALU_DIV || i_alu_op == ALU_DIVU) ?
                    '1 : i_data_1;
      else
         spec_res = (i_alu_op == ALU_DIV) ? i_data_1 : '0;
   end

   always_comb begin
      prod   = {core_hi, core_lo};
      prod_n = sign_q ? -prod : prod;
      quot_n = sign_q ? -core_lo : core_lo;
      rem_n  = sign_q ? -core_hi : core_hi;
      unique case (op_q)
         ALU_MULH, ALU_MULHSU, ALU_MULHU:
            md_res = prod_n[2*XLEN-1:XLEN];
         ALU_DIV, ALU_DIVU: md_res = quot_n;
         ALU_REM, ALU_REMU: md_res = rem_n;
         default:           md_res = prod_n[XLEN-1:0];
      endcase
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      sign_d   = sign_q;
      result_d = result_q;
      start    = 1'b0;
      if (i_flush) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (i_valid) begin
                  op_d   = i_alu_op;
                  sign_d = sgn_in;
                  if (div_op && (div0 || ovf)) begin
                     result_d = spec_res;
                     state_d  = ST_DONE;
                  end else if (mul_op) begin
                     start   = 1'b1;
                     state_d = ST_MUL;
                  end else if (div_op) begin
                     start   = 1'b1;
                     state_d = ST_DIV;
                  end else begin
                     result_d = base_res;
                     state_d  = ST_DONE;
                  end
               end
            end
            ST_MUL, ST_DIV: begin
               if (core_done) begin
                  result_d = md_res;
                  state_d  = ST_DONE;
               end
            end
            ST_DONE: begin
               if (i_ready)
                  state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   alu_muldiv_core #(
      .XLEN (XLEN)
   ) u_core (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_start (start),
      .i_flush (i_flush),
      .i_div   (div_op),
      .i_a     (a_mag),
      .i_b     (b_mag),
      .o_done  (core_done),
      .o_hi    (core_hi),
      .o_lo    (core_lo)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= ST_IDLE;
         op_q     <= '0;
         sign_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         sign_q   <= sign_d;
         result_q <= result_d;
      end
   end

   assign o_ready  = (state_q == ST_IDLE);
   assign o_valid  = (state_q == ST_DONE);
   assign o_busy   = (state_q == ST_MUL) || (state_q == ST_DIV);
   assign o_result = result_q;

endmodule

// File: tb/tb_alu_iter.sv
// Directed bench for alu_iter: op vectors, latency, backpressure,
// flush and asynchronous reset.
module tb_alu_iter;
   import alu_iter_pkg::*;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic [4:0]  i_alu_op = '0;
   logic [31:0] i_data_1 = '0;
   logic [31:0] i_data_2 = '0;
   logic        i_flush = 1'b0;
   logic        o_valid;
   logic        i_ready = 1'b1;
   logic [31:0] o_result;
   logic        o_busy;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   alu_iter #(.XLEN(32), .SHW(5), .OPW(5)) dut (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_valid  (i_valid),
      .o_ready  (o_ready),
      .i_alu_op (i_alu_op),
      .i_data_1 (i_data_1),
      .i_data_2 (i_data_2),
      .i_flush  (i_flush),
      .o_valid  (o_valid),
      .i_ready  (i_ready),
      .o_result (o_result),
      .o_busy   (o_busy)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Drive a request once the block is idle; returns just after the
   // accepting edge with the inputs scrambled.
   task automatic issue(input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b);
      int g = 0;
      @(negedge i_clk);
      while (!o_ready && g < 100) begin
         @(negedge i_clk);
         g++;
      end
      if (!o_ready)
         check("ready_timeout", 32'(o_ready), 32'd1);
      i_valid  = 1'b1;
      i_alu_op = op;
      i_data_1 = a;
      i_data_2 = b;
      @(posedge i_clk);
      #1;
      i_valid  = 1'b0;
      i_alu_op = 5'(ALU_SUB);
      i_data_1 = $urandom;
      i_data_2 = $urandom;
   endtask

   task automatic wait_valid(output int lat, output int busy,
                             output int rdy_bad);
      lat = 1;
      busy = 0;
      rdy_bad = 0;
      while (!o_valid && lat < 200) begin
         if (o_busy) busy++;
         if (o_ready) rdy_bad++;
         @(posedge i_clk);
         #1;
         lat++;
      end
   endtask

   initial begin
      int lat, busy, bad, seen;

      vecs.push_back('{ALU_ADD,    32'h7FFFFFFF, 32'h1, 32'h80000000, 1});
      vecs.push_back('{ALU_SLT,    32'hFFFFFFFF, 32'h1, 32'h1, 1});
      vecs.push_back('{ALU_SLTU,   32'hFFFFFFFF, 32'h1, 32'h0, 1});
      vecs.push_back('{ALU_SRA,    32'h80000000, 32'h21, 32'hC0000000, 1});
      vecs.push_back('{ALU_SUB,    32'h5, 32'h7, 32'hFFFFFFFE, 1});
      vecs.push_back('{ALU_SLL,    32'h1, 32'h24, 32'h10, 1});
      vecs.push_back('{ALU_EQ,     32'h9, 32'h9, 32'h1, 1});
      vecs.push_back('{ALU_GEU,    32'h1, 32'hFFFFFFFF, 32'h0, 1});
      vecs.push_back('{ALU_GE,     32'h1, 32'hFFFFFFFF, 32'h1, 1});
      vecs.push_back('{5'd31,      32'h3, 32'h4, 32'h7, 1});
      vecs.push_back('{ALU_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 33});
      vecs.push_back('{ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33});
      vecs.push_back('{ALU_MUL,    32'h7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33});
      vecs.push_back('{ALU_MULHSU, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 33});
      vecs.push_back('{ALU_DIV,    32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 33});
      vecs.push_back('{ALU_REM,    32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 33});
      vecs.push_back('{ALU_DIVU,   32'h80000000, 32'h0, 32'hFFFFFFFF, 1});
      vecs.push_back('{ALU_REM,    32'h80000000, 32'hFFFFFFFF, 32'h0, 1});
      vecs.push_back('{ALU_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
      vecs.push_back('{ALU_REMU,   32'h1234, 32'h0, 32'h1234, 1});
      vecs.push_back('{ALU_DIVU,   32'd100, 32'd7, 32'd14, 33});
      vecs.push_back('{ALU_REMU,   32'd100, 32'd7, 32'd2, 33});

      repeat (3) @(posedge i_clk);
      #1;
      check("rst_ready", 32'(o_ready), 32'd1);
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_result", o_result, 32'd0);
      @(negedge i_clk);
      i_rst_n = 1'b1;

      foreach (vecs[i]) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b);
         wait_valid(lat, busy, bad);
         check($sformatf("v%0d_res", i), o_result, vecs[i].exp);
         check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
         check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].lat - 1));
         check($sformatf("v%0d_rdy", i), 32'(bad), 32'd0);
      end
      @(posedge i_clk);
      #1;
      check("post_ready", 32'(o_ready), 32'd1);

      // Backpressure: result held, new requests ignored.
      @(negedge i_clk);
      i_ready = 1'b0;
      issue(ALU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_valid(lat, busy, bad);
      check("bp_lat", 32'(lat), 32'd33);
      for (int k = 0; k < 5; k++) begin
         @(negedge i_clk);
         i_valid  = 1'b1;
         i_alu_op = ALU_ADD;
         i_data_1 = 32'd1;
         i_data_2 = 32'd1;
         @(posedge i_clk);
         #1;
         check("bp_valid", 32'(o_valid), 32'd1);
         check("bp_hold", o_result, 32'hFFFFFFFE);
         check("bp_ready", 32'(o_ready), 32'd0);
      end
      @(negedge i_clk);
      i_valid = 1'b0;
      i_ready = 1'b1;
      @(posedge i_clk);
      #1;
      check("bp_rel_ready", 32'(o_ready), 32'd1);
      check("bp_rel_valid", 32'(o_valid), 32'd0);

      // Flush a divide sampled on the 10th edge after acceptance.
      issue(ALU_DIV, 32'd100, 32'd7);
      repeat (9) @(posedge i_clk);
      @(negedge i_clk);
      i_flush = 1'b1;
      @(posedge i_clk);
      #1;
      i_flush = 1'b0;
      check("fl_valid", 32'(o_valid), 32'd0);
      check("fl_ready", 32'(o_ready), 32'd1);
      check("fl_busy", 32'(o_busy), 32'd0);
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge i_clk);
         #1;
         if (o_valid) seen++;
      end
      check("fl_no_valid", 32'(seen), 32'd0);
      issue(ALU_ADD, 32'd2, 32'd3);
      wait_valid(lat, busy, bad);
      check("fl_add_res", o_result, 32'd5);
      check("fl_add_lat", 32'(lat), 32'd1);

      // Asynchronous reset between edges, mid-multiply.
      issue(ALU_MUL, 32'd3, 32'd5);
      repeat (5) @(posedge i_clk);
      #2;
      check("ar_busy_pre", 32'(o_busy), 32'd1);
      i_rst_n = 1'b0;
      #1;
      check("ar_valid", 32'(o_valid), 32'd0);
      check("ar_busy", 32'(o_busy), 32'd0);
      check("ar_result", o_result, 32'd0);
      check("ar_ready", 32'(o_ready), 32'd1);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;
      check("ar_rel_ready", 32'(o_ready), 32'd1);
      check("ar_rel_valid", 32'(o_valid), 32'd0);
      check("ar_rel_result", o_result, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
